// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and queued load returns onto the single
// register-file write port, squashing queued loads overwritten by younger ALU writes.
module wb_arbiter #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    input  logic [4:0]                 alu_rd,
    input  logic [XLEN-1:0]            alu_data,
    input  logic                       lsu_valid,
    output logic                       lsu_ready,
    input  logic [4:0]                 lsu_rd,
    input  logic [XLEN-1:0]            lsu_data,
    output logic                       wr_en,
    output logic [4:0]                 wr_reg,
    output logic [XLEN-1:0]            wr_data,
    output logic [$clog2(DEPTH+1)-1:0] lsu_count
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [DEPTH-1:0] live_q, live_d;
    logic [4:0]       rd_q   [DEPTH];
    logic [4:0]       rd_d   [DEPTH];
    logic [XLEN-1:0]  data_q [DEPTH];
    logic [XLEN-1:0]  data_d [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_en_q, wr_en_d;
    logic [4:0]       wr_reg_q, wr_reg_d;
    logic [XLEN-1:0]  wr_data_q, wr_data_d;

    logic alu_fire, push, pop, head_live;

    // Readiness depends only on registered occupancy, never on the current pop.
    assign lsu_ready = (count_q < CW'(DEPTH));
    assign lsu_count = count_q;
    assign wr_en     = wr_en_q;
    assign wr_reg    = wr_reg_q;
    assign wr_data   = wr_data_q;

    always_comb begin
        alu_fire  = alu_valid && (alu_rd != 5'd0);
        push      = lsu_valid && lsu_ready && (lsu_rd != 5'd0);
        head_live = live_q[rd_ptr_q];
        pop       = (count_q != '0) && (!head_live || !alu_fire);

        live_d    = live_q;
        rd_d      = rd_q;
        data_d    = data_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        wr_en_d   = 1'b0;
        wr_reg_d  = wr_reg_q;
        wr_data_d = wr_data_q;

        // Younger ALU write kills any queued load to the same register.
        for (int i = 0; i < DEPTH; i++) begin
            if (alu_fire && (rd_q[i] == alu_rd)) begin
                live_d[i] = 1'b0;
            end
        end

        if (pop) begin
            live_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = rd_ptr_q + PW'(1);
        end

        // A same-cycle load is older than the ALU result, so it enters dead.
        if (push) begin
            live_d[wr_ptr_q] = !(alu_fire && (lsu_rd == alu_rd));
            rd_d[wr_ptr_q]   = lsu_rd;
            data_d[wr_ptr_q] = lsu_data;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end

        count_d = count_q + CW'(push) - CW'(pop);

        if (alu_fire) begin
            wr_en_d   = 1'b1;
            wr_reg_d  = alu_rd;
            wr_data_d = alu_data;
        end else if (pop && head_live) begin
            wr_en_d   = 1'b1;
            wr_reg_d  = rd_q[rd_ptr_q];
            wr_data_d = data_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q    <= '0;
            rd_q      <= '{default: '0};
            data_q    <= '{default: '0};
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
        end else begin
            live_q    <= live_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            wr_en_q   <= wr_en_d;
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic, checked by a
// queue-based reference model feeding a write scoreboard.
module tb_wb_arbiter;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              alu_valid;
    logic [4:0]        alu_rd;
    logic [XLEN-1:0]   alu_data;
    logic              lsu_valid;
    logic              lsu_ready;
    logic [4:0]        lsu_rd;
    logic [XLEN-1:0]   lsu_data;
    logic              wr_en;
    logic [4:0]        wr_reg;
    logic [XLEN-1:0]   wr_data;
    logic [1:0]        lsu_count;

    wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data), .lsu_count(lsu_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit              live;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } entry_t;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wr_t;

    entry_t model_q[$];
    wr_t    sb_q[$];
    int     n_cmp = 0;
    int     n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every DUT write must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && wr_en) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_write_reg", 64'(wr_reg), 64'hFFFF);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                chk("wr_reg", 64'(wr_reg), 64'(e.rd));
                chk("wr_data", 64'(wr_data), 64'(e.data));
            end
        end
    end

    // One clock of stimulus; the model is stepped from the spec's rules.
    task automatic cycle(input bit av, input logic [4:0] ard, input logic [XLEN-1:0] ad,
                         input bit lv, input logic [4:0] lrd, input logic [XLEN-1:0] ld,
                         output bit accepted);
        bit fire;
        bit rdy;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
        rdy  = (model_q.size() < DEPTH);
        fire = av && (ard != 0);
        chk("lsu_ready", 64'(lsu_ready), 64'(rdy));
        chk("lsu_count", 64'(lsu_count), 64'(model_q.size()));
        accepted = lv && rdy;
        if (model_q.size() > 0) begin
            if (!model_q[0].live) begin
                void'(model_q.pop_front());
            end else if (!fire) begin
                sb_q.push_back('{rd: model_q[0].rd, data: model_q[0].data});
                void'(model_q.pop_front());
            end
        end
        if (fire) begin
            sb_q.push_back('{rd: ard, data: ad});
            foreach (model_q[i]) if (model_q[i].rd == ard) model_q[i].live = 0;
        end
        if (accepted && lrd != 0)
            model_q.push_back('{live: !(fire && lrd == ard), rd: lrd, data: ld});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, acc);
    endtask

    task automatic drain(input string name);
        idle(DEPTH + 3);
        @(negedge clk);
        #1;
        chk({name, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
        chk({name, "_count"}, 64'(lsu_count), 64'd0);
    endtask

    task automatic do_reset();
        alu_valid = 0; lsu_valid = 0;
        rst = 1'b1;
        #1;
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_wr_reg", 64'(wr_reg), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_count", 64'(lsu_count), 64'd0);
        chk("rst_ready", 64'(lsu_ready), 64'd1);
        model_q.delete();
        sb_q.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        bit acc;
        logic [4:0] ard, lrd;
        rst = 1'b1;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Single load, ALU idle.
        cycle(0, 0, 0, 1, 5, 32'hDEADBEEF, acc);
        cycle(0, 0, 0, 0, 0, 0, acc);
        chk("single_wr_en", 64'(wr_en), 64'd1);
        chk("single_wr_reg", 64'(wr_reg), 64'd5);
        chk("single_wr_data", 64'(wr_data), 64'hDEADBEEF);
        drain("single");

        // Priority and backpressure.
        cycle(1, 1, 32'h101, 1, 10, 32'hA0, acc);
        cycle(1, 2, 32'h102, 1, 11, 32'hA1, acc);
        chk("bp_ready_full", 64'(lsu_ready), 64'd0);
        cycle(1, 3, 32'h103, 1, 12, 32'hA2, acc);
        chk("bp_third_rejected", 64'(acc), 64'd0);
        cycle(1, 4, 32'h104, 1, 12, 32'hA2, acc);
        acc = 0;
        for (int i = 0; i < 8 && !acc; i++) cycle(0, 0, 0, 1, 12, 32'hA2, acc);
        chk("bp_third_accepted", 64'(acc), 64'd1);
        drain("bp");

        // Squash of a queued load.
        cycle(0, 0, 0, 1, 7, 32'h11, acc);
        cycle(1, 7, 32'h22, 0, 0, 0, acc);
        drain("squash");

        // Same-cycle squash.
        cycle(1, 9, 32'hAA, 1, 9, 32'hBB, acc);
        chk("same_cycle_count", 64'(lsu_count), 64'd1);
        drain("same_squash");

        // Writes to x0 are filtered.
        cycle(1, 0, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, acc);
        chk("x0_wr_en", 64'(wr_en), 64'd0);
        chk("x0_count", 64'(lsu_count), 64'd0);
        drain("x0");

        // Reset with two loads queued behind ALU traffic.
        cycle(1, 1, 32'h1, 1, 3, 32'h33, acc);
        cycle(1, 2, 32'h2, 1, 4, 32'h44, acc);
        chk("pre_rst_count", 64'(lsu_count), 64'd2);
        do_reset();
        drain("post_rst");

        // Random traffic with a narrow register range to provoke squashes.
        for (int n = 0; n < 3000; n++) begin
            ard = 5'($urandom_range(0, 7));
            lrd = 5'($urandom_range(0, 7));
            cycle(($urandom_range(0, 99) < 55), ard, $urandom,
                  ($urandom_range(0, 99) < 60), lrd, $urandom, acc);
            if (n == 1500) do_reset();
        end
        drain("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter for the RV32 core, sitting directly upstream of the register file write port. It merges single-cycle ALU results and variable-latency load returns from the LSU onto the register file's single write port (`wr_en`/`wr_reg`/`wr_data`). Load returns are queued in a small FIFO with a valid/ready handshake. Younger ALU writes squash queued loads to the same register, preserving write-after-write order. Writes to x0 are never issued.

## Interface
- `XLEN`, 32, datapath width
- `DEPTH`, 2, load-return FIFO entries (power of two, ≥2)
- `clk`  in  1  core clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `alu_valid`  in  1  ALU result present this cycle (cannot be stalled)
- `alu_rd`  in  5  ALU destination register
- `alu_data`  in  XLEN  ALU result
- `lsu_valid`  in  1  load return offered
- `lsu_ready`  out  1  FIFO can accept a load return
- `lsu_rd`  in  5  load destination register
- `lsu_data`  in  XLEN  load data
- `wr_en`  out  1  register file write enable
- `wr_reg`  out  5  register file write address
- `wr_data`  out  XLEN  register file write data
- `lsu_count`  out  $clog2(DEPTH+1)  FIFO occupancy (live + dead entries)

## Operation
- Reset is asynchronous and active-high: one clock, `rst` asserted clears the FIFO (count 0, all entries dead) and sets `wr_en`/`wr_reg`/`wr_data` to 0 immediately. Any in-flight load is lost.
- Load handshake: a beat is accepted when `lsu_valid && lsu_ready`.
  - `lsu_ready` = (`lsu_count` < DEPTH), computed from registered state only, never from `lsu_valid`.
  - Full FIFO → `lsu_ready`=0, even if a pop occurs that cycle.
  - An accepted beat with `lsu_rd`==0 is discarded, not enqueued.
- Each FIFO entry holds {live, rd, data}.
- ALU write (A): asserted when `alu_valid && alu_rd!=0`. A always wins the write port. `alu_valid` with `alu_rd`==0 is ignored entirely.
- Squash: when A fires with rd=R:
  - every FIFO entry with rd==R has its live bit cleared;
  - a load beat accepted the same cycle with `lsu_rd`==R is enqueued dead. Same-cycle loads are older than the ALU result.
- Pop, per cycle:
  - Head dead → pop it with no write, regardless of A.
  - Head live and A not firing → pop it and write it.
  - Head live and A firing → head stays.
  - At most one pop per cycle.
- Push and pop in the same cycle are allowed; count is unchanged.
- Pointers wrap modulo DEPTH; `lsu_count` ranges 0..DEPTH.

## Timing
- Output registered: the selection made at edge N (from inputs and state before edge N) appears on `wr_en`/`wr_reg`/`wr_data` after edge N. The register file commits at edge N+1.
- ALU result → `wr_en` high: 1 cycle.
- Load return → earliest `wr_en` high: 2 cycles (enqueue at edge N, pop at edge N+1). No bypass.
- `wr_en`=0 in any cycle with no write. `wr_reg`/`wr_data` hold their last written values when `wr_en`=0.
- `wr_en` is never high with `wr_reg`==0.
- `lsu_ready` and `lsu_count` update one edge after push/pop.
- Sustained `alu_valid` starves loads: the FIFO fills and `lsu_ready` stays 0 until an ALU bubble. No starvation timeout.

## Test plan
- Reset: assert `rst` mid-traffic with 2 queued loads → outputs 0 immediately, `lsu_count`=0, `lsu_ready`=1, and no stale write after release.
- Single load: ALU idle, load {rd=5, 0xDEADBEEF} accepted at edge 0 → `wr_en`=1, `wr_reg`=5, `wr_data`=0xDEADBEEF after edge 1, `lsu_count` back to 0.
- Priority/backpressure: `alu_valid` every cycle to rd=1..4 while 3 loads are offered → 2 accepted, `lsu_ready`=0 on the third. After the ALU stops, loads drain in order, one per cycle.
- Squash: queue load {rd=7, 0x11}, then ALU {rd=7, 0x22} → only the 0x22 write to x7 is seen. The dead entry pops with `wr_en`=0 and `lsu_count` returns to 0.
- Same-cycle squash: ALU {rd=9, 0xAA} and load {rd=9, 0xBB} accepted in the same cycle → only 0xAA is written to x9.
- x0 filtering: ALU rd=0 and load rd=0 with data 0xFFFFFFFF → `wr_en` never asserts, `lsu_count` stays 0.
